// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the shared-resource arbiter.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (output req, input gnt, sel, busy, timeout);
  modport slave  (input req, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a Mux4 onto one shared resource; registered one-hot
// grant with a MAX_HOLD tenure limit so a busy owner cannot starve the others.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pick;

  // Search from base+1 upward with wrap; base itself ranks last. Descending loop so
  // the nearest hit is written last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick = rr_pick(bus.req, last_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          last_d  = pick;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        // Release outranks timeout: a dropping owner never produces a pulse.
        if (!bus.req[sel_q]) begin
          if (|bus.req) begin
            gnt_d  = 4'b0001 << pick;
            sel_d  = pick;
            last_d = pick;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          timeout_d = 1'b1;
          gnt_d     = 4'b0001 << pick;
          sel_d     = pick;
          last_d    = pick;
          cnt_d     = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      last_q    <= 2'd3;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed vector table for mux4_rr_arbiter (MAX_HOLD=4) plus an async-reset sequence.
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mux4_rr_arbiter_if bus_if ();

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] s,
                       input logic b, input logic t);
    checks++;
    if (bus_if.gnt !== g || bus_if.sel !== s || bus_if.busy !== b || bus_if.timeout !== t) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
               name, bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.timeout, g, s, b, t);
    end
  endtask

  initial begin
    // Round-robin walk and wrap
    tbl.push_back('{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
    // Single requester 2 for three cycles; sel holds after release
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
    // Owner 1 times out in favour of 3
    tbl.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1});
    tbl.push_back('{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0});
    // Lone requester 2 re-granted on each timeout
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1});
    tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
    // Release on the timeout edge: handoff without a pulse
    tbl.push_back('{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0});
    // Set up the mid-grant reset: owner 3
    tbl.push_back('{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});

    bus_if.req = 4'b0000;
    #12;
    check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      bus_if.req = tbl[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].to);
    end

    // Async reset while owner 3 holds the grant: outputs clear with no clock edge
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus_if.req = 4'b1111;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("priority_restart_0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
